lane_rr_sched: RTL and testbench
================================

Name: lane_rr_sched

Overview:
- Round-robin scheduler that shares one sampling/observation port among NLANES generate-replicated sample lanes.
- Each lane raises a request. The scheduler grants one lane at a time and captures that lane's value into a shared sample register. It holds the grant for a fixed number of cycles, then moves on.
- Sits between the generate-for lane array and the single shared checker/observer, so only one lane is sampled per window.

Parameters:
- NLANES, 4, number of requesting lanes (2..16).
- IDXW, 2, width of lane index; must satisfy 2**IDXW >= NLANES.
- HOLD_CYC, 2, cycles a grant stays asserted (1..15).
- CNTW, 16, width of the saturating grant counter.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NLANES, per-lane request, level-sensitive.
- lane_value, input, NLANES, per-lane 1-bit sample value.
- grant, output, NLANES, one-hot grant; all-zero when idle.
- grant_idx, output, IDXW, index of the granted lane; valid only while grant_valid=1.
- grant_valid, output, 1, high while any grant is asserted.
- sample_out, output, 1, value captured from the granted lane.
- sample_valid, output, 1, one-cycle pulse when sample_out updates.
- grant_count, output, CNTW, total grants issued; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - grant=0, grant_idx=0, grant_valid=0, sample_out=0, sample_valid=0, grant_count=0.
  - State=IDLE; last-granted pointer=NLANES-1, so lane 0 wins first.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - At a posedge with req!=0, select the first requesting lane searching upward from last+1, wrapping modulo NLANES.
  - On that edge: grant<=onehot(sel), grant_idx<=sel, grant_valid<=1, hold counter<=HOLD_CYC-1, last<=sel, grant_count<=grant_count+1 (saturating), state<=HOLD.
  - Latency: a request seen at edge N gives grant visible after edge N.
- Sample capture:
  - At the first edge of HOLD, sample_out<=lane_value[grant_idx] and sample_valid<=1 for exactly that one cycle.
  - sample_valid=0 at all other times; sample_out keeps its value otherwise.
- HOLD:
  - Hold counter decrements each edge.
  - When the counter is 0, or req[grant_idx]=0 (early release), that edge clears grant/grant_valid; state<=GAP.
  - Early release still produces the sample if it happens on the first HOLD edge.
- GAP:
  - Exactly one cycle with no grant; guarantees a grant-free cycle between owners.
  - Then state<=IDLE. Arbitration happens at the IDLE edge, so back-to-back grants are HOLD_CYC+2 cycles apart.
- Requests:
  - Requests that arrive or vanish during HOLD/GAP have no effect until IDLE.
  - A lane dropping and re-raising req mid-window is not remembered.
- Fairness: with all lanes requesting continuously, the grant sequence is 0,1,2,...,NLANES-1,0,... with no lane skipped.
- Single requester: the same lane is re-granted every HOLD_CYC+2 cycles.
- HOLD_CYC=1: grant is asserted for one cycle, then GAP.
- grant_count: stops at 2**CNTW-1 and never wraps.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), the pointer is reset, and any pending sample is discarded.
- Invariants (bench assertions):
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_idx matches the set grant bit.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> grant=0, grant_valid=0, sample_valid never pulses, grant_count=0.
- req=4'b1111 held, lane_value=4'b1010, HOLD_CYC=2 -> grant_idx sequence 0,1,2,3,0 at 4-cycle spacing; sample_out 0,1,0,1,0; grant_count=5 after the fifth grant.
- req=4'b0100 only -> lane 2 granted every 4 cycles, grant=4'b0100 for 2 cycles, then 2 cycles of 0.
- Lane 1 granted, req[1] drops on cycle 1 of HOLD -> grant clears at the next edge, one GAP cycle, then lane 2 (also requesting) is granted; lane 1 is not re-granted before lanes 2 and 3.
- rst_n pulled low mid-HOLD with lane 3 granted -> grant=0 and grant_valid=0 immediately without waiting for clk; after release with req=4'b1111, lane 0 is granted first.
- CNTW=4, continuous requests for 20 grants -> grant_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/lane_rr_sched_if.sv
// Bundle of lane request/sample inputs and scheduler grant/sample outputs.
// The lane side uses master; the scheduler uses slave.
interface lane_rr_sched_if #(
    parameter int NLANES = 4,
    parameter int IDXW   = 2,
    parameter int CNTW   = 16
);
    logic [NLANES-1:0] req;
    logic [NLANES-1:0] lane_value;
    logic [NLANES-1:0] grant;
    logic [IDXW-1:0]   grant_idx;
    logic              grant_valid;
    logic              sample_out;
    logic              sample_valid;
    logic [CNTW-1:0]   grant_count;

    modport master (
        output req, lane_value,
        input  grant, grant_idx, grant_valid, sample_out, sample_valid, grant_count
    );

    modport slave (
        input  req, lane_value,
        output grant, grant_idx, grant_valid, sample_out, sample_valid, grant_count
    );
endinterface

// File: rtl/lane_rr_sched.sv
// Round-robin scheduler granting one lane at a time to a shared sample register.
// Each grant lasts HOLD_CYC cycles (or less on early release) followed by one idle gap cycle.
module lane_rr_sched #(
    parameter int NLANES   = 4,
    parameter int IDXW     = 2,
    parameter int HOLD_CYC = 2,
    parameter int CNTW     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lane_rr_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

    localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYC - 1);
    localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NLANES - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [3:0]        hold_q, hold_d;
    logic [NLANES-1:0] grant_q, grant_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              gvalid_q, gvalid_d;
    logic              sample_q, sample_d;
    logic              svalid_q, svalid_d;
    logic [CNTW-1:0]   count_q, count_d;

    logic              found;
    logic [IDXW-1:0]   sel;

    // Search upward from the lane after the last owner, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NLANES; i++) begin
            int c;
            c = (int'(last_q) + i) % NLANES;
            if (!found && bus.req[c]) begin
                found = 1'b1;
                sel   = IDXW'(c);
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        hold_d   = hold_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        gvalid_d = gvalid_q;
        sample_d = sample_q;
        svalid_d = 1'b0;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = {{(NLANES-1){1'b0}}, 1'b1} << sel;
                    idx_d    = sel;
                    gvalid_d = 1'b1;
                    hold_d   = HOLD_INIT;
                    last_d   = sel;
                    if (count_q != '1) count_d = count_q + CNTW'(1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // Counter still at its load value marks the first HOLD edge.
                if (hold_q == HOLD_INIT) begin
                    sample_d = bus.lane_value[idx_q];
                    svalid_d = 1'b1;
                end
                if (hold_q == 4'd0 || !bus.req[idx_q]) begin
                    grant_d  = '0;
                    gvalid_d = 1'b0;
                    state_d  = GAP;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            hold_q   <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            gvalid_q <= 1'b0;
            sample_q <= 1'b0;
            svalid_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            gvalid_q <= gvalid_d;
            sample_q <= sample_d;
            svalid_q <= svalid_d;
            count_q  <= count_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_idx    = idx_q;
    assign bus.grant_valid  = gvalid_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = svalid_q;
    assign bus.grant_count  = count_q;
endmodule

// File: tb/tb_lane_rr_sched.sv
// Directed bench for lane_rr_sched: a main instance (CNTW=16) and a CNTW=4 instance
// sharing stimulus so the saturating counter can be exercised.
module tb_lane_rr_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lane_value = '0;
    int         n_checks = 0;
    int         n_pass = 0;

    lane_rr_sched_if #(.NLANES(4), .IDXW(2), .CNTW(16)) bus ();
    lane_rr_sched_if #(.NLANES(4), .IDXW(2), .CNTW(4))  bus_s ();

    assign bus.req          = req;
    assign bus.lane_value   = lane_value;
    assign bus_s.req        = req;
    assign bus_s.lane_value = lane_value;

    lane_rr_sched #(.NLANES(4), .IDXW(2), .HOLD_CYC(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    lane_rr_sched #(.NLANES(4), .IDXW(2), .HOLD_CYC(2), .CNTW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Structural invariants on both instances, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ($countones(bus.grant) > 1 || bus.grant_valid !== (|bus.grant) ||
                (bus.grant_valid && bus.grant !== (4'b0001 << bus.grant_idx)))
                $display("FAIL inv_main: grant=%b idx=%0d valid=%b", bus.grant, bus.grant_idx, bus.grant_valid);
            else n_pass++;
            n_checks++;
            if ($countones(bus_s.grant) > 1 || bus_s.grant_valid !== (|bus_s.grant) ||
                (bus_s.grant_valid && bus_s.grant !== (4'b0001 << bus_s.grant_idx)))
                $display("FAIL inv_small: grant=%b idx=%0d valid=%b", bus_s.grant, bus_s.grant_idx, bus_s.grant_valid);
            else n_pass++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit pulsed;
        #2;
        n_checks++;
        if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 2'd0)
            $display("FAIL reset_grant: got grant=%b valid=%b idx=%0d want 0/0/0", bus.grant, bus.grant_valid, bus.grant_idx);
        else n_pass++;
        n_checks++;
        if (bus.sample_out !== 1'b0 || bus.sample_valid !== 1'b0 || bus.grant_count !== 16'd0)
            $display("FAIL reset_sample: got out=%b sv=%b cnt=%0d want 0/0/0", bus.sample_out, bus.sample_valid, bus.grant_count);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.grant_valid || bus.grant != 4'b0 || bus.sample_valid) pulsed = 1'b1;
        end
        n_checks++;
        if (pulsed !== 1'b0) $display("FAIL idle_quiet: got activity=%b want 0", pulsed);
        else n_pass++;
        n_checks++;
        if (bus.grant_count !== 16'd0) $display("FAIL idle_count: got %0d want 0", bus.grant_count);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_smp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        req = 4'b1111;
        lane_value = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_idx[k] || bus.grant !== (4'b0001 << exp_idx[k]))
                $display("FAIL rr_grant%0d: got valid=%b idx=%0d grant=%b want idx %0d", k, bus.grant_valid, bus.grant_idx, bus.grant, exp_idx[k]);
            else n_pass++;
            step();
            n_checks++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== exp_smp[k] || bus.grant_valid !== 1'b1)
                $display("FAIL rr_sample%0d: got sv=%b out=%b gv=%b want 1/%b/1", k, bus.sample_valid, bus.sample_out, bus.grant_valid, exp_smp[k]);
            else n_pass++;
            step();
            n_checks++;
            if (bus.grant_valid !== 1'b0 || bus.sample_valid !== 1'b0)
                $display("FAIL rr_gap%0d: got gv=%b sv=%b want 0/0", k, bus.grant_valid, bus.sample_valid);
            else n_pass++;
            step();
        end
        n_checks++;
        if (bus.grant_count !== 16'd5) $display("FAIL rr_count: got %0d want 5", bus.grant_count);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0] exp_g [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        req = 4'b0100;
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (bus.grant !== exp_g[c])
                    $display("FAIL single_w%0d_c%0d: got grant=%b want %b", w, c, bus.grant, exp_g[c]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_early_release();
        logic [1:0] exp_seq [3] = '{2'd2, 2'd3, 2'd1};
        req = 4'b0110;
        step();
        n_checks++;
        if (bus.grant !== 4'b0010) $display("FAIL early_grant: got %b want 0010", bus.grant);
        else n_pass++;
        req = 4'b0100;
        step();
        n_checks++;
        if (bus.grant_valid !== 1'b0 || bus.sample_valid !== 1'b1 || bus.sample_out !== 1'b1)
            $display("FAIL early_release: got gv=%b sv=%b out=%b want 0/1/1", bus.grant_valid, bus.sample_valid, bus.sample_out);
        else n_pass++;
        step();
        n_checks++;
        if (bus.grant_valid !== 1'b0) $display("FAIL early_gap: got gv=%b want 0", bus.grant_valid);
        else n_pass++;
        req = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_seq[k])
                $display("FAIL early_seq%0d: got valid=%b idx=%0d want 1/%0d", k, bus.grant_valid, bus.grant_idx, exp_seq[k]);
            else n_pass++;
            if (k < 2) begin
                step();
                step();
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        req = 4'b1000;
        step();
        step();
        n_checks++;
        if (bus.grant !== 4'b1000) $display("FAIL mid_pre: got grant=%b want 1000", bus.grant);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_count !== 16'd0)
            $display("FAIL mid_async: got grant=%b gv=%b cnt=%0d want 0/0/0", bus.grant, bus.grant_valid, bus.grant_count);
        else n_pass++;
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd0)
            $display("FAIL mid_restart: got gv=%b idx=%0d want 1/0", bus.grant_valid, bus.grant_idx);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [3:0] exp_c;
        rst_n = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_c = (k >= 15) ? 4'd15 : 4'(k);
            n_checks++;
            if (bus_s.grant_count !== exp_c)
                $display("FAIL sat_count%0d: got %0d want %0d", k, bus_s.grant_count, exp_c);
            else n_pass++;
            step();
            step();
            step();
        end
        n_checks++;
        if (bus.grant_count !== 16'd20) $display("FAIL wide_count: got %0d want 20", bus.grant_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_early_release();
        test_reset_mid();
        test_saturation();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
